// File: rtl/aes_pkg.sv
// Shared AES-128 definitions for the iterative core.
//   NR / NK      : round count and key length in words
//   state_e      : sequencer states of aes_iter
//   xtime, gmul  : GF(2^8) arithmetic over x^8+x^4+x^3+x+1
//   rpc_legal    : true for the supported rounds-per-clock values
//   sbox, sub_bytes, shift_rows, mix_columns : AES round transforms
// State vectors are 128 bits with byte 0 (s[0,0]) in bits 127:120,
// bytes running down the columns (byte n = s[n%4, n/4]).
package aes_pkg;

    localparam int NR = 10;
    localparam int NK = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic bit rpc_legal(input int rpc);
        return (rpc == 1) || (rpc == 2) || (rpc == 5) || (rpc == 10);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (0 maps to 0), then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] r;
        t = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) o[8*n +: 8] = sbox(s[8*n +: 8]);
        return o;
    endfunction

    // Row r of the output takes column (c + r) mod 4 of the input.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = s[127-8*(4*(((n/4) + (n%4)) % 4) + (n%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                 xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
        end
        return o;
    endfunction

endpackage

// File: rtl/aes_iter_if.sv
// Block handshake bundle for aes_iter.
//   in_valid/in_ready  : block offer and acceptance
//   in_key/in_data     : cipher key and plaintext, sampled on accept
//   out_valid/out_ready: ciphertext offer and acceptance
//   out_data           : ciphertext
// master = block source/sink side, slave = the core.
interface aes_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_key;
    logic [127:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_key, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_key, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: RotWord, SubWord and rcon on the last
// word, then the XOR chain across the four words.
//   key_i  : current round key (word 0 in bits 127:96)
//   rcon_i : round constant for this step
//   key_o  : next round key
module aes_key_round
    import aes_pkg::*;
(
    input  logic [127:0] key_i,
    input  logic [7:0]   rcon_i,
    output logic [127:0] key_o
);

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] rot, temp;
    logic [31:0] n0, n1, n2, n3;

    assign w0   = key_i[127:96];
    assign w1   = key_i[95:64];
    assign w2   = key_i[63:32];
    assign w3   = key_i[31:0];
    assign rot  = {w3[23:0], w3[31:24]};
    assign temp = {sbox(rot[31:24]) ^ rcon_i, sbox(rot[23:16]),
                   sbox(rot[15:8]), sbox(rot[7:0])};
    assign n0   = w0 ^ temp;
    assign n1   = w1 ^ n0;
    assign n2   = w2 ^ n1;
    assign n3   = w3 ^ n2;
    assign key_o = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_iter.sv
// Iterative AES-128 encryption core, RPC rounds per clock, key expanded
// on the fly alongside the state.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : slave side of aes_iter_if (block in, ciphertext out)
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a block; in_ready high
// BUSY    | RPC rounds per cycle until round 10 has been applied
// DONE    | ciphertext held on out_data until out_ready; can re-accept
module aes_iter
    import aes_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic       clk,
    input  logic       rst,
    aes_iter_if.slave  bus
);

    if (!rpc_legal(RPC)) begin : g_bad_rpc
        $error("aes_iter: RPC must be 1, 2, 5 or 10");
    end

    state_e       state_q, state_d;
    logic [127:0] st_q, st_d;
    logic [127:0] key_q, key_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] out_q, out_d;

    logic         accept;
    logic [127:0] st_nx, key_nx;
    logic [7:0]   rcon_nx;
    logic [3:0]   round_nx;

    for (genvar g = 0; g < RPC; g++) begin : g_round
        logic [127:0] st_in, key_in, st_out, key_out, sr, mc;
        logic [7:0]   rcon_in, rcon_out;
        logic [3:0]   rnd_in, rnd_out;

        if (g == 0) begin : g_first
            assign st_in   = st_q;
            assign key_in  = key_q;
            assign rcon_in = rcon_q;
            assign rnd_in  = round_q;
        end else begin : g_next
            assign st_in   = g_round[g-1].st_out;
            assign key_in  = g_round[g-1].key_out;
            assign rcon_in = g_round[g-1].rcon_out;
            assign rnd_in  = g_round[g-1].rnd_out;
        end

        aes_key_round u_key_round (
            .key_i  (key_in),
            .rcon_i (rcon_in),
            .key_o  (key_out)
        );

        assign rnd_out  = rnd_in + 4'd1;
        assign rcon_out = xtime(rcon_in);
        assign sr       = shift_rows(sub_bytes(st_in));
        assign mc       = mix_columns(sr);
        // The final round skips MixColumns.
        assign st_out   = ((rnd_out == 4'(NR)) ? sr : mc) ^ key_out;
    end

    assign st_nx    = g_round[RPC-1].st_out;
    assign key_nx   = g_round[RPC-1].key_out;
    assign rcon_nx  = g_round[RPC-1].rcon_out;
    assign round_nx = g_round[RPC-1].rnd_out;

    assign bus.in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & bus.out_ready);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.out_data  = out_q;
    assign accept        = bus.in_valid & bus.in_ready;

    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        key_d   = key_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        out_d   = out_q;

        case (state_q)
            ST_BUSY: begin
                st_d    = st_nx;
                key_d   = key_nx;
                rcon_d  = rcon_nx;
                round_d = round_nx;
                if (round_nx == 4'(NR)) begin
                    state_d = ST_DONE;
                    out_d   = st_nx;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) state_d = ST_IDLE;
            end
            default: ;
        endcase

        // accept is only possible in IDLE or in DONE with out_ready high.
        if (accept) begin
            state_d = ST_BUSY;
            st_d    = bus.in_data ^ bus.in_key;
            key_d   = bus.in_key;
            rcon_d  = 8'h01;
            round_d = 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            st_q    <= '0;
            key_q   <= '0;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            key_q   <= key_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_aes_iter.sv
// Testbench for aes_iter: four cores (RPC = 1, 2, 5, 10) on one clock,
// known-answer vectors plus random blocks against a table-driven AES model.
module tb_aes_iter;

    logic clk;
    logic rst;

    logic [3:0]        in_valid_v, in_ready_v, out_valid_v, out_ready_v;
    logic [3:0][127:0] in_key_v, in_data_v, out_data_v;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [127:0] KB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KC = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PC = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    for (genvar i = 0; i < 4; i++) begin : g_dut
        localparam int R = (i == 0) ? 1 : (i == 1) ? 2 : (i == 2) ? 5 : 10;
        aes_iter_if bus ();
        assign bus.in_valid   = in_valid_v[i];
        assign bus.in_key     = in_key_v[i];
        assign bus.in_data    = in_data_v[i];
        assign bus.out_ready  = out_ready_v[i];
        assign in_ready_v[i]  = bus.in_ready;
        assign out_valid_v[i] = bus.out_valid;
        assign out_data_v[i]  = bus.out_data;
        aes_iter #(.RPC(R)) u_dut (.clk(clk), .rst(rst), .bus(bus));
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    logic [7:0] ex_t [256];
    logic [7:0] lg_t [256];
    logic [7:0] sb_t [256];

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'h00 || b == 8'h00) return 8'h00;
        return ex_t[(int'(lg_t[a]) + int'(lg_t[b])) % 255];
    endfunction

    task automatic build_tables();
        logic [7:0] x, inv, sv, c;
        c = 8'h63;
        x = 8'h01;
        for (int i = 0; i < 255; i++) begin
            ex_t[i] = x;
            lg_t[x] = 8'(i);
            x = x ^ {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        ex_t[255] = ex_t[0];
        lg_t[0]   = 8'h00;
        for (int a = 0; a < 256; a++) begin
            inv = (a == 0) ? 8'h00 : ex_t[(255 - int'(lg_t[a])) % 255];
            for (int i = 0; i < 8; i++)
                sv[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                        ^ inv[(i+7)%8] ^ c[i];
            sb_t[a] = sv;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   w [176];
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   tmp [4];
        logic [7:0]   rc, sw, a0, a1, a2, a3;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8] ^ w[i];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                sw     = tmp[0];
                tmp[0] = sb_t[tmp[1]] ^ rc;
                tmp[1] = sb_t[tmp[2]];
                tmp[2] = sb_t[tmp[3]];
                tmp[3] = sb_t[sw];
                rc     = gm(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int r = 1; r <= 10; r++) begin
            for (int row = 0; row < 4; row++)
                for (int col = 0; col < 4; col++)
                    t[row + 4*col] = sb_t[s[row + 4*((col + row) % 4)]];
            if (r < 10) begin
                for (int col = 0; col < 4; col++) begin
                    a0 = t[4*col]; a1 = t[4*col+1]; a2 = t[4*col+2]; a3 = t[4*col+3];
                    t[4*col]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
                    t[4*col+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
                    t[4*col+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
                    t[4*col+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
                end
            end
            for (int n = 0; n < 16; n++) s[n] = t[n] ^ w[16*r + n];
        end
        for (int n = 0; n < 16; n++) res[127-8*n -: 8] = s[n];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Offer one block, scramble the inputs while it is in flight, and
    // check latency and ciphertext.
    task automatic run_block(input int d, input logic [127:0] key, input logic [127:0] pt,
                             input logic [127:0] ct, input int lat, input string tag);
        int n;
        in_key_v[d]   = key;
        in_data_v[d]  = pt;
        in_valid_v[d] = 1'b1;
        n = 0;
        while (in_ready_v[d] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk({tag, " in_ready"}, 128'(in_ready_v[d]), 128'(1));
        tick();
        in_valid_v[d] = 1'b0;
        n = 0;
        while (out_valid_v[d] !== 1'b1 && n < 60) begin
            in_key_v[d]  = rnd128();
            in_data_v[d] = rnd128();
            tick();
            n++;
        end
        chk({tag, " latency"}, 128'(n), 128'(lat));
        chk({tag, " ct"}, out_data_v[d], ct);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int rpc_tbl [4];
        int n;
        logic [127:0] k1, p1, k2, p2;
        rpc_tbl = '{1, 2, 5, 10};

        rst         = 1'b0;
        in_valid_v  = '0;
        out_ready_v = '1;
        in_key_v    = '0;
        in_data_v   = '0;
        build_tables();

        repeat (3) tick();
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("reset out_valid d%0d", d), 128'(out_valid_v[d]), 128'(0));
            chk($sformatf("reset out_data d%0d", d), out_data_v[d], 128'(0));
        end
        rst = 1'b1;
        tick();
        chk("post-reset in_ready", 128'(in_ready_v[0]), 128'(1));

        run_block(0, KB, PB, CB, 10, "appB rpc1");
        for (int d = 0; d < 4; d++)
            run_block(d, KC, PC, CC, 10 / rpc_tbl[d], $sformatf("appC rpc%0d", rpc_tbl[d]));

        for (int d = 0; d < 4; d++)
            for (int b = 0; b < 2; b++) begin
                k1 = rnd128();
                p1 = rnd128();
                run_block(d, k1, p1, aes_ref(k1, p1), 10 / rpc_tbl[d],
                          $sformatf("rand rpc%0d #%0d", rpc_tbl[d], b));
            end

        // Back-to-back on RPC=1 with out_ready held high.
        tick();
        in_key_v[0]   = KB;
        in_data_v[0]  = PB;
        in_valid_v[0] = 1'b1;
        tick();
        in_key_v[0]  = KC;
        in_data_v[0] = PC;
        n = 0;
        while (out_valid_v[0] !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("b2b first latency", 128'(n), 128'(10));
        chk("b2b first ct", out_data_v[0], CB);
        chk("b2b ready in done", 128'(in_ready_v[0]), 128'(1));
        tick();
        in_valid_v[0] = 1'b0;
        chk("b2b second accepted", 128'(out_valid_v[0]), 128'(0));
        n = 1;
        while (out_valid_v[0] !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("b2b output spacing", 128'(n), 128'(11));
        chk("b2b second ct", out_data_v[0], CC);
        tick();

        // Backpressure: hold out_ready low with a second block pending.
        k1 = rnd128(); p1 = rnd128();
        k2 = rnd128(); p2 = rnd128();
        out_ready_v[0] = 1'b0;
        in_key_v[0]    = k1;
        in_data_v[0]   = p1;
        in_valid_v[0]  = 1'b1;
        tick();
        in_key_v[0]  = k2;
        in_data_v[0] = p2;
        n = 0;
        while (out_valid_v[0] !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk("bp latency", 128'(n), 128'(10));
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("bp hold ct %0d", i), out_data_v[0], aes_ref(k1, p1));
            chk($sformatf("bp hold in_ready %0d", i), 128'(in_ready_v[0]), 128'(0));
            tick();
        end
        chk("bp still valid", 128'(out_valid_v[0]), 128'(1));
        chk("bp still ct", out_data_v[0], aes_ref(k1, p1));
        out_ready_v[0] = 1'b1;
        #1;
        chk("bp ready on release", 128'(in_ready_v[0]), 128'(1));
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        chk("bp pending accepted", 128'(out_valid_v[0]), 128'(0));
        n = 0;
        while (out_valid_v[0] !== 1'b1 && n < 60) begin
            in_key_v[0]  = rnd128();
            in_data_v[0] = rnd128();
            tick();
            n++;
        end
        chk("bp second latency", 128'(n), 128'(10));
        chk("bp second ct", out_data_v[0], aes_ref(k2, p2));
        tick();

        // Reset during BUSY cycle 4.
        in_key_v[0]   = KC;
        in_data_v[0]  = PC;
        in_valid_v[0] = 1'b1;
        tick();
        in_valid_v[0] = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        for (int d = 0; d < 4; d++) begin
            chk($sformatf("midrst out_valid d%0d", d), 128'(out_valid_v[d]), 128'(0));
            chk($sformatf("midrst out_data d%0d", d), out_data_v[d], 128'(0));
        end
        repeat (12) tick();
        chk("midrst no output", 128'(out_valid_v[0]), 128'(0));
        rst = 1'b1;
        tick();
        run_block(0, KC, PC, CC, 10, "after reset appC");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
